prog_sequencer: RTL
===================

Name: prog_sequencer

Overview:
- Top-level run controller directly upstream of the fetch stage.
- Accepts a program-run request, drives fetch's start / start_address / halt inputs, and counts executed cycles.
- Detects end-of-program (halt instruction reported by decode) or watchdog timeout, then parks the core with halt asserted.
- Lets the testbench or host launch the team's programs back-to-back without resetting the core.

Parameters:
- PC_W, 7, width of instruction address (matches fetch/PC).
- NUM_PROGS, 3, number of launchable programs; ids 0..NUM_PROGS-1 valid.
- CNT_W, 16, width of cycle counter.
- MAX_CYCLES, 16'hFFFF, watchdog limit in RUN cycles; must be at least 1 and at most 2**CNT_W-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  1  run request; sampled only in IDLE or DONE.
- req_prog  in  2  program id accompanying req.
- instr_halt  in  1  decode reports the current instruction is HALT.
- start  out  1  to fetch: load start_address into PC this cycle.
- start_address  out  PC_W  to fetch: selected program entry point.
- halt  out  1  to fetch: freeze PC.
- busy  out  1  high in LOAD and RUN.
- done  out  1  high in DONE.
- timeout  out  1  valid while done; 1 means the run ended by watchdog.
- bad_req  out  1  one-cycle pulse when req carries an invalid id.
- cycle_count  out  CNT_W  RUN cycles of the current or last run.

Behaviour:
- Reset (async assert, sync release): state=IDLE, start=0, start_address=0, halt=1, busy=0, done=0, timeout=0, bad_req=0, cycle_count=0.
- All outputs are registered; no combinational path from inputs to outputs.
- States are IDLE, LOAD, RUN, DONE.
- IDLE: halt=1. On req=1:
  - req_prog<NUM_PROGS: go to LOAD and latch start_address=PROG_START[req_prog].
  - req_prog>=NUM_PROGS: bad_req=1 for 1 cycle, stay in IDLE.
- LOAD (exactly 1 cycle): start=1, halt=0, busy=1, cycle_count cleared to 0, done=0, timeout=0. Next state is RUN.
- RUN: start=0, halt=0, busy=1, cycle_count increments by 1 every cycle.
  - instr_halt=1: go to DONE with timeout=0; cycle_count includes that cycle.
  - Otherwise, when the increment makes cycle_count==MAX_CYCLES: go to DONE with timeout=1.
  - instr_halt and watchdog in the same cycle: halt wins, timeout=0.
  - req is ignored in RUN (no bad_req either).
- DONE: halt=1, done=1, busy=0. cycle_count and timeout hold. Request handling is the same as IDLE:
  - Valid req: go to LOAD; done drops the following cycle.
  - Invalid req: bad_req pulse, stay in DONE.
- Latency: req sampled at edge N puts start=1 in the cycle after edge N; fetch's first instruction address appears on the PC after the next edge.
- cycle_count never wraps, because MAX_CYCLES<=2**CNT_W-1.
- Reset mid-run: immediate IDLE with halt=1; the run is lost and no done is asserted.
- instr_halt outside RUN is ignored.

Decomposition:
- Package seq_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - PROG_START, a NUM_PROGS-entry array of PC_W-wide constants (defaults 0, 40, 80);
  - PC_W shared with fetch and PC.
- Sub-module cycle_counter: clear / enable / saturate-at-limit, with a reached-limit flag. Natural to split out; the FSM stays in prog_sequencer.

Test Plan:
- Reset with no req → halt=1, start=0, done=0, cycle_count=0, held for 5 cycles.
- req=1, req_prog=1 for 1 cycle → next cycle start=1, start_address=40, halt=0; then busy=1 and count increments. instr_halt asserted in the 6th RUN cycle → done=1, timeout=0, cycle_count=6, halt=1.
- MAX_CYCLES=8, program never halts → after 8 RUN cycles done=1, timeout=1, cycle_count=8. Repeat with instr_halt pulsed on the 8th cycle → timeout=0, cycle_count=8.
- req_prog=3 in IDLE → bad_req pulses 1 cycle, state stays IDLE, start never asserts. req during RUN → no effect, no bad_req.
- Back-to-back: from DONE, req_prog=2 → start_address=80, done drops, cycle_count restarts from 0.
- reset_n pulsed low mid-RUN (not on a clock edge) → outputs return to reset values immediately; done never asserts.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the program run controller: the FSM state type,
// the instruction address width and the table of program entry points.
package seq_pkg;

    // Instruction address width, shared with fetch and the PC.
    localparam int PC_W = 7;

    // Number of programs that have an entry point in the table below.
    localparam int NUM_PROGS = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    // Entry point of each launchable program.
    localparam logic [PC_W-1:0] PROG_START [NUM_PROGS] = '{7'd0, 7'd40, 7'd80};

    // Entry point for a program id; ids without a table entry map to 0.
    function automatic logic [PC_W-1:0] prog_start_of(input logic [1:0] id);
        logic [PC_W-1:0] addr;
        addr = '0;
        for (int i = 0; i < NUM_PROGS; i++) begin
            if (id == 2'(i)) begin
                addr = PROG_START[i];
            end
        end
        return addr;
    endfunction

endpackage

// File: rtl/cycle_counter.sv
// Run-length counter: synchronous clear, count enable, saturates at LIMIT.
// last_o flags that the increment happening this cycle lands on LIMIT.
module cycle_counter #(
    parameter int                CNT_W = 16,
    parameter logic [CNT_W-1:0]  LIMIT = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [CNT_W-1:0] count_o,
    output logic             last_o
);

    localparam logic [CNT_W-1:0] LAST = LIMIT - CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins over increment; never step past LIMIT.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LIMIT)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = enable_i && (count_q == LAST);

endmodule

// File: rtl/prog_sequencer.sv
// Run controller sitting in front of fetch: launches a program on request,
// counts RUN cycles, and parks the core on HALT or watchdog expiry.
module prog_sequencer #(
    parameter int                PC_W       = seq_pkg::PC_W,
    parameter int unsigned       NUM_PROGS  = seq_pkg::NUM_PROGS,
    parameter int                CNT_W      = 16,
    parameter logic [CNT_W-1:0]  MAX_CYCLES = '1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req,
    input  logic [1:0]       req_prog,
    input  logic             instr_halt,
    output logic             start,
    output logic [PC_W-1:0]  start_address,
    output logic             halt,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             bad_req,
    output logic [CNT_W-1:0] cycle_count
);

    import seq_pkg::*;

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic [PC_W-1:0]   addr_q;
    logic [PC_W-1:0]   addr_d;
    logic              timeout_q;
    logic              timeout_d;
    logic              start_q;
    logic              halt_q;
    logic              busy_q;
    logic              done_q;
    logic              bad_req_q;

    logic              accept_window;
    logic              id_ok;
    logic              launch;
    logic              reject;
    logic              cnt_last;

    // Requests are only looked at while parked (IDLE or DONE).
    assign accept_window = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign id_ok         = ({30'd0, req_prog} < 32'(NUM_PROGS));
    assign launch        = accept_window && req && id_ok;
    assign reject        = accept_window && req && !id_ok;

    cycle_counter #(
        .CNT_W (CNT_W),
        .LIMIT (MAX_CYCLES)
    ) u_cycle_counter (
        .clk_i    (clock),
        .rst_ni   (reset_n),
        .clear_i  (launch),
        .enable_i (state_q == ST_RUN),
        .count_o  (cycle_count),
        .last_o   (cnt_last)
    );

    // Next state, latched entry point and end-of-run cause.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (launch) begin
                    state_d   = ST_LOAD;
                    addr_d    = PC_W'(prog_start_of(req_prog));
                    timeout_d = 1'b0;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // HALT has priority over a watchdog expiry in the same cycle.
                if (instr_halt) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b0;
                end else if (cnt_last) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State plus output registers; outputs are decoded from the next state
    // so every output comes straight off a flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            timeout_q <= 1'b0;
            start_q   <= 1'b0;
            halt_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bad_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            timeout_q <= timeout_d;
            start_q   <= (state_d == ST_LOAD);
            halt_q    <= (state_d == ST_IDLE) || (state_d == ST_DONE);
            busy_q    <= (state_d == ST_LOAD) || (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
            bad_req_q <= reject;
        end
    end

    assign start         = start_q;
    assign start_address = addr_q;
    assign halt          = halt_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign timeout       = timeout_q;
    assign bad_req       = bad_req_q;

endmodule
